// File: rtl/cerere_pietoni.sv
// Pedestrian request controller: sync + debounce button, latch request until green, then cooldown.
// Latency: button sampled high at edge k -> buton high after edge k+2+DEBOUNCE_CYCLES.
// No backpressure: the request level is held until verde_pietoni grants it.
module cerere_pietoni #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int COOLDOWN_CYCLES = 16,
   parameter int WAIT_W          = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              apasat,
   input  logic              verde_pietoni,
   output logic              buton,
   output logic              asteapta,
   output logic [WAIT_W-1:0] timp_asteptare,
   output logic [7:0]        cereri_servite
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CD_W-1:0]   CD_MAX   = CD_W'(COOLDOWN_CYCLES - 1);
   localparam logic [WAIT_W-1:0] TIMP_MAX = {WAIT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, CERERE, SERVIRE, PAUZA} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_s1;
   logic              r_s2;
   logic              r_filt;
   logic              r_filt_d;
   logic [DB_W-1:0]   r_db_cnt;
   logic [CD_W-1:0]   r_cd_cnt;
   logic              r_pending;
   logic              r_buton;
   logic [WAIT_W-1:0] r_timp;
   logic [7:0]        r_servite;
   logic              w_press;
   logic              w_cd_last;

   assign w_press   = r_filt & ~r_filt_d;
   assign w_cd_last = (r_cd_cnt == CD_MAX);

   // Two-flop synchroniser followed by a consecutive-sample debounce filter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_filt   <= 1'b0;
         r_filt_d <= 1'b0;
         r_db_cnt <= '0;
      end else begin
         r_s1     <= apasat;
         r_s2     <= r_s1;
         r_filt_d <= r_filt;
         if (r_s2 == r_filt) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_MAX) begin
            r_filt   <= r_s2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   // Next-state logic: a press only opens a request from IDLE or at the end of cooldown.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_press) w_next = CERERE;
         CERERE:  if (verde_pietoni) w_next = SERVIRE;
         SERVIRE: if (!verde_pietoni) w_next = PAUZA;
         PAUZA:   if (w_cd_last) w_next = (r_pending || w_press) ? CERERE : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register plus request level, cooldown, pending flag and statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_buton   <= 1'b0;
         r_cd_cnt  <= '0;
         r_pending <= 1'b0;
         r_timp    <= '0;
         r_servite <= '0;
      end else begin
         r_state <= w_next;
         r_buton <= (w_next == CERERE);

         // Counter idles at zero, so it is already cleared on entry to PAUZA.
         if (r_state == PAUZA && !w_cd_last)
            r_cd_cnt <= r_cd_cnt + 1'b1;
         else
            r_cd_cnt <= '0;

         if (r_state == PAUZA)
            r_pending <= w_cd_last ? 1'b0 : (r_pending | w_press);
         else
            r_pending <= 1'b0;

         // Wait time restarts on entry and keeps its value outside CERERE.
         if (w_next == CERERE && r_state != CERERE)
            r_timp <= '0;
         else if (r_state == CERERE && r_timp != TIMP_MAX)
            r_timp <= r_timp + 1'b1;

         if (r_state == CERERE && verde_pietoni)
            r_servite <= r_servite + 1'b1;
      end
   end

   assign buton          = r_buton;
   assign asteapta       = r_buton;
   assign timp_asteptare = r_timp;
   assign cereri_servite = r_servite;

endmodule

// File: tb/tb_cerere_pietoni.sv
// Randomised bench for cerere_pietoni: reference model predicts outputs, monitor compares.
// Model pushes one expected output set per clock edge; monitor pops on the falling edge.
// Stimulus is free-running random runs of button/grant levels plus rare resets.
module tb_cerere_pietoni;

   localparam int D = 4;
   localparam int C = 16;
   localparam int W = 8;
   localparam int N_CYCLES = 40000;

   logic         clk = 1'b0;
   logic         rst;
   logic         apasat;
   logic         verde;
   logic         buton;
   logic         asteapta;
   logic [W-1:0] timp;
   logic [7:0]   servite;

   always #5 clk = ~clk;

   cerere_pietoni #(
      .DEBOUNCE_CYCLES(D),
      .COOLDOWN_CYCLES(C),
      .WAIT_W(W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .apasat(apasat),
      .verde_pietoni(verde),
      .buton(buton),
      .asteapta(asteapta),
      .timp_asteptare(timp),
      .cereri_servite(servite)
   );

   typedef struct packed {
      logic         buton;
      logic         asteapta;
      logic [W-1:0] timp;
      logic [7:0]   servite;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_served_total = 0;

   typedef enum {P_IDLE, P_WAIT, P_CROSS, P_COOL} phase_t;

   // Reference model state (values after the most recent edge)
   phase_t m_phase;
   logic   m_s1, m_s2, m_filt, m_filt_prev;
   logic   m_run_val;
   int     m_run;
   int     m_cool_left;
   bit     m_pend;
   int     m_timp;
   int     m_served;

   // Reference model: filtered level changes once the synchronised input has held
   // a value different from it for D edges; request phases follow the service rules.
   always @(posedge clk) begin : model_p
      exp_t e;
      logic press;
      logic v;
      logic nf;
      if (rst) begin
         m_phase = P_IDLE; m_s1 = 0; m_s2 = 0; m_filt = 0; m_filt_prev = 0;
         m_run_val = 0; m_run = 0; m_cool_left = 0; m_pend = 0;
         m_timp = 0; m_served = 0;
      end else begin
         press = m_filt && !m_filt_prev;
         v = m_s2;
         if (v == m_run_val) begin
            if (m_run < 100000) m_run++;
         end else begin
            m_run_val = v;
            m_run = 1;
         end
         nf = m_filt;
         if (v != m_filt && m_run >= D) nf = v;
         m_filt_prev = m_filt;
         m_filt = nf;
         m_s2 = m_s1;
         m_s1 = apasat;
         case (m_phase)
            P_IDLE: if (press) begin m_phase = P_WAIT; m_timp = 0; end
            P_WAIT: begin
               if (m_timp < (1 << W) - 1) m_timp++;
               if (verde) begin
                  m_phase = P_CROSS;
                  m_served = (m_served + 1) % 256;
                  n_served_total++;
               end
            end
            P_CROSS: if (!verde) begin m_phase = P_COOL; m_cool_left = C; end
            P_COOL: begin
               if (press) m_pend = 1;
               m_cool_left--;
               if (m_cool_left == 0) begin
                  if (m_pend) begin m_phase = P_WAIT; m_timp = 0; end
                  else m_phase = P_IDLE;
                  m_pend = 0;
               end
            end
            default: m_phase = P_IDLE;
         endcase
      end
      e.buton    = (m_phase == P_WAIT);
      e.asteapta = (m_phase == P_WAIT);
      e.timp     = W'(m_timp);
      e.servite  = 8'(m_served);
      q.push_back(e);
   end

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp_v);
      end
   endtask

   // Monitor: compare settled outputs against the oldest prediction.
   always @(negedge clk) begin : mon_p
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("buton", int'(buton), int'(e.buton));
         check("asteapta", int'(asteapta), int'(e.asteapta));
         check("timp_asteptare", int'(timp), int'(e.timp));
         check("cereri_servite", int'(servite), int'(e.servite));
      end
   end

   // Stimulus: random-length runs on both inputs (short runs are glitches).
   initial begin : stim_p
      int a_left;
      int v_left;
      rst = 1'b1; apasat = 1'b0; verde = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      // Clean press held 20 cycles, long wait, then a grant
      apasat = 1'b1;
      repeat (20) @(negedge clk);
      apasat = 1'b0;
      repeat (25) @(negedge clk);
      verde = 1'b1;
      repeat (10) @(negedge clk);
      verde = 1'b0;
      repeat (30) @(negedge clk);
      a_left = 1;
      v_left = 1;
      for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 2999) == 0);
         a_left--;
         if (a_left <= 0) begin
            apasat = ~apasat;
            if ($urandom_range(0, 3) == 0) a_left = $urandom_range(1, D - 1);
            else if (apasat) a_left = $urandom_range(D + 1, 25);
            else a_left = $urandom_range(D + 1, 60);
         end
         v_left--;
         if (v_left <= 0) begin
            verde = ~verde;
            if (verde) v_left = $urandom_range(1, 12);
            else if ($urandom_range(0, 9) == 0) v_left = $urandom_range(260, 320);
            else v_left = $urandom_range(1, 60);
         end
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
